// File: rtl/phase_sequencer.sv
// Multi-cycle phase generator for the core control decoder: phases 1..NPHASE per
// instruction, memory wait-state stalls with timeout, halt/resume and single-step.
module phase_sequencer #(
  parameter int NPHASE     = 5,
  parameter int PHASE_W    = 3,
  parameter int MEM_PHASE  = 3,
  parameter int WAIT_LIMIT = 8,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step_mode,
  input  logic               hlt,
  input  logic               mem_ready,
  output logic [PHASE_W-1:0] phase,
  output logic               last_phase,
  output logic               retire,
  output logic               running,
  output logic               halted,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int WW_RAW = $clog2(WAIT_LIMIT + 1);
  localparam int WW     = (WW_RAW < 1) ? 1 : WW_RAW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic            in_mem, stall, tmo_hit;

  assign last_phase = (phase == PHASE_W'(NPHASE));
  assign in_mem     = (phase == PHASE_W'(MEM_PHASE));
  assign stall      = in_mem && !mem_ready;
  // Timeout fires on the WAIT_LIMIT-th consecutive stalled cycle instead of holding.
  assign tmo_hit    = stall && (WAIT_LIMIT != 0) &&
                      (wait_cnt == WW'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= '0;
      retire      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_RUN: begin
          if (hlt) begin
            state    <= S_HALT;
            phase    <= '0;
            running  <= 1'b0;
            halted   <= 1'b1;
            wait_cnt <= '0;
          end else if (tmo_hit) begin
            state       <= S_HALT;
            phase       <= '0;
            running     <= 1'b0;
            halted      <= 1'b1;
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
          end else if (stall) begin
            if (wait_cnt != {WW{1'b1}}) wait_cnt <= wait_cnt + WW'(1);
          end else begin
            wait_cnt <= '0;
            if (last_phase) begin
              retire      <= 1'b1;
              instr_count <= instr_count + CNT_W'(1);
              if (step_mode) begin
                state   <= S_PAUSE;
                phase   <= '0;
                running <= 1'b0;
              end else begin
                phase <= PHASE_W'(1);
              end
            end else begin
              phase <= phase + PHASE_W'(1);
            end
          end
        end
        default: begin
          // IDLE, PAUSE and HALT all resume at phase 1 on start.
          if (start) begin
            if (state == S_HALT) timeout_err <= 1'b0;
            state    <= S_RUN;
            phase    <= PHASE_W'(1);
            running  <= 1'b1;
            halted   <= 1'b0;
            wait_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: sequencing, stall, timeout, halt, step, wrap, reset.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, step_mode, hlt, mem_ready;
  logic [2:0] phase;
  logic       last_phase, retire, running, halted, timeout_err;
  logic [3:0] instr_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  phase_sequencer #(
    .NPHASE(5), .PHASE_W(3), .MEM_PHASE(3), .WAIT_LIMIT(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .hlt(hlt),
    .mem_ready(mem_ready), .phase(phase), .last_phase(last_phase),
    .retire(retire), .running(running), .halted(halted),
    .timeout_err(timeout_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input int ph, input int ret, input int run);
    chk({tag, " phase"}, 32'(phase), 32'(ph));
    chk({tag, " retire"}, 32'(retire), 32'(ret));
    chk({tag, " running"}, 32'(running), 32'(run));
    chk({tag, " count"}, 32'(instr_count), 32'(exp_cnt));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " outs"}, {25'd0, phase, last_phase, retire, running, halted, timeout_err},
        32'd0);
    chk({tag, " count"}, 32'(instr_count), 32'd0);
  endtask

  // Called in a phase-1 cycle; runs phases 2..NPHASE and the retire cycle.
  task automatic run_instr(input string tag);
    for (int p = 2; p <= 5; p++) begin
      tick();
      cyc(tag, p, 0, 1);
    end
    chk({tag, " last"}, 32'(last_phase), 32'd1);
    tick();
    exp_cnt = (exp_cnt + 1) % 16;
    cyc({tag, " ret"}, 1, 1, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; hlt = 1'b0; mem_ready = 1'b1;
    #2;
    all_zero("reset");
    #10 rst = 1'b0;
    tick();
    all_zero("idle");

    // Free-running sequence
    start = 1'b1; tick(); start = 1'b0;
    cyc("start", 1, 0, 1);
    chk("start last", 32'(last_phase), 32'd0);
    for (int i = 0; i < 3; i++) run_instr("seq");

    // Two-cycle memory stall in phase 3
    tick(); cyc("st p2", 2, 0, 1);
    mem_ready = 1'b0;
    tick(); cyc("st p3", 3, 0, 1);
    tick(); cyc("st hold1", 3, 0, 1);
    tick(); cyc("st hold2", 3, 0, 1);
    mem_ready = 1'b1;
    tick(); cyc("st p4", 4, 0, 1);
    tick(); cyc("st p5", 5, 0, 1);
    tick(); exp_cnt++; cyc("st ret", 1, 1, 1);
    chk("st tmo", 32'(timeout_err), 32'd0);

    // Timeout after four stalled cycles
    tick(); cyc("to p2", 2, 0, 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); cyc("to p3", 3, 0, 1);
    end
    tick();
    cyc("to halt", 0, 0, 0);
    chk("to halted", 32'(halted), 32'd1);
    chk("to err", 32'(timeout_err), 32'd1);
    mem_ready = 1'b1;
    tick(); tick();
    chk("to stay", 32'({halted, timeout_err}), 32'b11);
    start = 1'b1; tick(); start = 1'b0;
    cyc("to resume", 1, 0, 1);
    chk("to err clr", 32'(timeout_err), 32'd0);
    chk("to halted clr", 32'(halted), 32'd0);

    // start ignored while running, then halt in phase 2
    start = 1'b1; tick(); start = 1'b0;
    cyc("ign start", 2, 0, 1);
    hlt = 1'b1; tick(); hlt = 1'b0;
    cyc("hlt", 0, 0, 0);
    chk("hlt halted", 32'(halted), 32'd1);
    chk("hlt err", 32'(timeout_err), 32'd0);
    tick(); cyc("hlt stay", 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    cyc("hlt resume", 1, 0, 1);

    // Single-step: pause after retire
    step_mode = 1'b1;
    for (int p = 2; p <= 5; p++) begin
      tick(); cyc("step", p, 0, 1);
    end
    tick(); exp_cnt++;
    cyc("step ret", 0, 1, 0);
    chk("step halted", 32'(halted), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(); cyc("paused", 0, 0, 0);
    end
    step_mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    cyc("step resume", 1, 0, 1);

    // Counter wrap through 15 -> 0 -> 1
    for (int i = 0; i < 17; i++) run_instr("wrap");

    // Reset mid-instruction in phase 3
    tick(); tick();
    cyc("pre rst", 3, 0, 1);
    #2 rst = 1'b1;
    #1 all_zero("async rst");
    tick(); all_zero("rst held");
    #3 rst = 1'b0;
    exp_cnt = 0;
    tick(); all_zero("post rst");
    tick(); all_zero("post rst idle");
    start = 1'b1; tick(); start = 1'b0;
    cyc("restart", 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
